branch_resolve_ctrl: RTL
========================

# branch_resolve_ctrl

Execute-stage controller that sequences the branch comparator for conditional branches. It accepts one branch at a time over a valid/ready handshake and registers the operands. It drives the comparator's operands and unsigned-select, then samples the equal/less-than flags. It resolves taken/not-taken against the fetch prediction and issues a held redirect request to fetch on a mispredict.

## Interface
- Parameters:
  - `XLEN`, 32: operand and PC width.
- Ports:
  - `clk`, input, 1: single clock; all state updates on the rising edge.
  - `rst_n`, input, 1: reset, asynchronous and active-low.
  - `br_valid`, input, 1: a branch is offered.
  - `br_ready`, output, 1: the block accepts a branch; equals `state==IDLE`.
  - `br_funct3`, input, 3: RV32I branch funct3.
  - `br_pc`, input, XLEN: PC of the branch.
  - `br_imm`, input, XLEN: sign-extended B-immediate.
  - `br_pred_taken`, input, 1: the prediction fetch used.
  - `rs1_data`, input, XLEN: first source operand.
  - `rs2_data`, input, XLEN: second source operand.
  - `cmp_a`, output, XLEN: comparator operand 1, registered.
  - `cmp_b`, output, XLEN: comparator operand 2, registered.
  - `cmp_un`, output, 1: unsigned-compare select, registered.
  - `cmp_eq`, input, 1: comparator equal flag, combinational from `cmp_a`/`cmp_b`/`cmp_un`.
  - `cmp_lt`, input, 1: comparator less-than flag, combinational from `cmp_a`/`cmp_b`/`cmp_un`.
  - `res_valid`, output, 1: one-cycle pulse when a branch resolves.
  - `res_taken`, output, 1: resolved direction; valid with `res_valid`.
  - `res_mispredict`, output, 1: `res_taken != pred`; valid with `res_valid`.
  - `res_illegal`, output, 1: funct3 was 010 or 011; valid with `res_valid`.
  - `redirect_valid`, output, 1: redirect request, held until accepted.
  - `redirect_ready`, input, 1: fetch accepts the redirect.
  - `redirect_pc`, output, XLEN: corrected next PC.
  - `flush`, input, 1: kill from an older instruction; highest priority.
  - `stat_branches`, output, 32: resolved-branch count; see Configuration.
  - `stat_mispredicts`, output, 32: mispredict count; see Configuration.

## Operation
- FSM states: IDLE, CMP, RESOLVE, REDIRECT.
- IDLE:
  - On `br_valid && !flush`, capture operands, funct3, pc, imm and pred.
  - Set `cmp_a=rs1_data`, `cmp_b=rs2_data`, `cmp_un=funct3[1]`.
  - Go to CMP.
- CMP: sample `cmp_eq`/`cmp_lt` into a register, then go to RESOLVE.
- Decode in RESOLVE:
  - 000 BEQ: taken = eq.
  - 001 BNE: taken = !eq.
  - 100 BLT and 110 BLTU: taken = lt.
  - 101 BGE and 111 BGEU: taken = !lt.
  - 010/011: taken=0, `res_illegal=1`.
- RESOLVE:
  - Pulse `res_valid` for one cycle.
  - On a mispredict: assert `redirect_valid` and go to REDIRECT.
  - Otherwise go to IDLE.
  - An illegal funct3 is a mispredict when pred=1.
- `redirect_pc`:
  - `pc+imm` if taken, else `pc+4`.
  - Both sums are modulo 2^XLEN; overflow wraps silently.
- REDIRECT: hold `redirect_valid` and `redirect_pc` stable until `redirect_ready`, then go to IDLE.
  - `redirect_ready` in the RESOLVE cycle itself completes the handshake and the FSM goes straight to IDLE.
- Flush:
  - In any state other than IDLE: the next state is IDLE, the in-flight branch is dropped, and there is no `res_valid`.
  - `redirect_valid` falls the next cycle.
  - Flush in the RESOLVE cycle does not suppress that cycle's `res_valid` pulse, but does suppress the redirect.
- Reset:
  - State goes to IDLE; all registered outputs and counters go to 0.
  - `br_ready` reads 1 in reset, because IDLE.
  - Reset mid-operation discards the branch with no redirect.

## Timing
- Cycle 0: handshake (`br_valid && br_ready`). Cycle 1: CMP, flags sampled. Cycle 2: RESOLVE, `res_valid` and first `redirect_valid`.
- Minimum initiation interval is 3 cycles; REDIRECT stalls add cycles.
- `cmp_*` are stable from cycle 1 until the next acceptance; the comparator path must close within one cycle.
- `res_*` are 0 except in the `res_valid` cycle.

## Configuration
- Macro: `BRANCH_STATS_EN`.
- Defined:
  - `stat_branches` increments on each `res_valid`.
  - `stat_mispredicts` increments on each `res_valid && res_mispredict`.
  - Both counters wrap at 2^32 and are cleared only by reset.
- Undefined: both stat outputs are tied to 0 and no counter flops exist.

## Test plan
- BEQ, rs1=rs2=0x5, pred=0, pc=0x100, imm=0x20 -> cycle 2: `res_taken=1`, `res_mispredict=1`, `redirect_pc=0x120`, `redirect_valid` held until `redirect_ready`.
- BLT rs1=0xFFFFFFFF, rs2=1, then BLTU with the same operands -> `cmp_un` 0 then 1; taken=1 then 0; each pred=taken gives no redirect.
- BGE pc=0xFFFFFFFC, not taken, pred=1 -> `redirect_pc=0x00000000` (wrap); `redirect_ready` low for 4 cycles keeps `redirect_valid` and pc stable.
- `flush` asserted in CMP -> no `res_valid`, FSM in IDLE next cycle, `br_ready=1`; with `br_valid=1` and `flush=1` in IDLE -> no acceptance.
- funct3=010 with pred=1 -> `res_illegal=1`, `res_taken=0`, redirect to `pc+4`; `rst_n` low during REDIRECT -> `redirect_valid=0` immediately.
- With `BRANCH_STATS_EN`, 10 branches with 3 mispredicts -> `stat_branches=10`, `stat_mispredicts=3`; without the macro -> both 0.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: execute-stage sequencer for conditional branches.
//
// The block accepts one branch over br_valid/br_ready and drives the external
// comparator. It resolves the branch direction and raises a held redirect to
// fetch on a mispredict.
//
// Ports:
//   clk, rst_n (async, active-low)
//   br_*            branch offer (funct3, pc, imm, prediction) + handshake
//   rs1/rs2_data    source operands
//   cmp_a/b/un      registered comparator inputs
//   cmp_eq/lt       comparator flags
//   res_*           one-cycle resolution pulse
//   redirect_*      redirect request to fetch
//   flush           kill from an older instruction
//   stat_*          resolution counters
//
// Optional feature: define BRANCH_STATS_EN to build the counters. When it is
// not defined, both stat outputs read 0.
module branch_resolve_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            br_pred_taken,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] cmp_a,
    output logic [XLEN-1:0] cmp_b,
    output logic            cmp_un,
    input  logic            cmp_eq,
    input  logic            cmp_lt,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            res_illegal,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESOLVE,
        REDIRECT
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] cmp_a_q;
    logic [XLEN-1:0] cmp_b_q;
    logic            cmp_un_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic            pred_q;
    logic            eq_q;
    logic            lt_q;

    logic            taken;
    logic            illegal;
    logic            mispredict;
    logic            in_resolve;

    // Direction decode works from the sampled flags. Those flags stay stable
    // through REDIRECT, so redirect_pc also holds while fetch stalls.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        unique case (funct3_q)
            3'b000:         taken = eq_q;
            3'b001:         taken = !eq_q;
            3'b100, 3'b110: taken = lt_q;
            3'b101, 3'b111: taken = !lt_q;
            default:        illegal = 1'b1;
        endcase
    end

    assign mispredict = (taken != pred_q);
    assign in_resolve = (state_q == RESOLVE);

    assign br_ready       = (state_q == IDLE);
    assign cmp_a          = cmp_a_q;
    assign cmp_b          = cmp_b_q;
    assign cmp_un         = cmp_un_q;
    assign res_valid      = in_resolve;
    assign res_taken      = in_resolve & taken;
    assign res_mispredict = in_resolve & mispredict;
    assign res_illegal    = in_resolve & illegal;

    // The redirect is first offered in RESOLVE, where a flush cancels it.
    // Once the FSM is in REDIRECT, a flush drops the request on the next
    // cycle.
    assign redirect_valid = (in_resolve && mispredict && !flush)
                          || (state_q == REDIRECT);
    assign redirect_pc    = taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmp_a_q  <= '0;
            cmp_b_q  <= '0;
            cmp_un_q <= 1'b0;
            funct3_q <= 3'b000;
            pc_q     <= '0;
            imm_q    <= '0;
            pred_q   <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (br_valid && !flush) begin
                        cmp_a_q  <= rs1_data;
                        cmp_b_q  <= rs2_data;
                        cmp_un_q <= br_funct3[1];
                        funct3_q <= br_funct3;
                        pc_q     <= br_pc;
                        imm_q    <= br_imm;
                        pred_q   <= br_pred_taken;
                        state_q  <= CMP;
                    end
                end
                CMP: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        eq_q    <= cmp_eq;
                        lt_q    <= cmp_lt;
                        state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (flush || !mispredict || redirect_ready) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (flush || redirect_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (in_resolve) begin
            br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict) begin
                mp_cnt_q <= mp_cnt_q + 32'd1;
            end
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
